// File: rtl/descrambler.sv
// Additive (synchronous) descrambler for s^7+s^4+1 on an AXI-Stream beat path.
// Keystream state is either recovered from each frame's first 7 bits or reloaded from SEED.
module descrambler #(
    parameter int         WIDTH   = 32,
    parameter logic [6:0] SEED    = 7'b1111111,
    parameter bit         RECOVER = 1'b1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic [15:0]      frame_count
);

    typedef enum logic {FIRST, BODY} state_t;

    state_t           state, state_nxt;
    logic [6:0]       lfsr, lfsr_nxt;
    logic [WIDTH+6:0] x_ext;
    logic [WIDTH-1:0] dout;
    logic             first, rec_first, s_hs;

    // Element k of the result is keystream bit x[k-7]; bits [6:0] are the
    // incoming state. When rec is set, x[0..6] come straight from the data.
    function automatic logic [WIDTH+6:0] gen_x(input logic [6:0] s,
                                               input logic [6:0] d,
                                               input logic       rec);
        logic [WIDTH+6:0] e;
        e      = '0;
        e[6:0] = s;
        for (int k = 7; k < 14; k++)
            e[k] = rec ? d[k-7] : (e[k-7] ^ e[k-4]);
        for (int k = 14; k < WIDTH + 7; k++)
            e[k] = e[k-7] ^ e[k-4];
        return e;
    endfunction

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign s_hs          = s_axis_tvalid & s_axis_tready;

    always_comb begin
        first     = (state == FIRST);
        rec_first = first && RECOVER;
        x_ext     = gen_x((first && !RECOVER) ? SEED : lfsr, s_axis_tdata[6:0], rec_first);
        dout      = s_axis_tdata ^ x_ext[WIDTH+6:7];
        if (rec_first)
            dout[6:0] = '0;
        lfsr_nxt  = x_ext[WIDTH+6:WIDTH];
        state_nxt = state;
        if (s_hs)
            state_nxt = s_axis_tlast ? FIRST : BODY;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= FIRST;
        else
            state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr          <= SEED;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_count   <= '0;
        end else if (s_hs) begin
            // A new beat may overwrite the register in the same cycle the old one drains.
            lfsr          <= lfsr_nxt;
            m_axis_tdata  <= dout;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= first;
            if (s_axis_tlast)
                frame_count <= 16'(frame_count + 16'd1);
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_descrambler.sv
// Randomized bench for descrambler: frames are scrambled by a bit-sequence model
// of s^7+s^4+1 and the recovered output is compared beat by beat.
module tb_descrambler;
    localparam int W = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [W-1:0]  m_data;
    logic          m_valid, m_last, m_user;
    logic          m_ready = 1'b1;
    logic [15:0]   fcnt;
    logic [W-1:0]  m0_data;
    logic          m0_valid, m0_last, m0_user, s0_ready;
    logic [15:0]   fcnt0;

    int            total = 0, bad = 0;
    int            ready_mode = 0;   // 0 always ready, 1 random, 2 never ready
    bit            mon_en = 1'b0;
    logic [W+1:0]  rx_q[$], exp_q[$];

    descrambler #(.WIDTH(W), .SEED(7'h7F), .RECOVER(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m_last), .m_axis_tuser(m_user), .frame_count(fcnt));

    descrambler #(.WIDTH(W), .SEED(7'h7F), .RECOVER(1'b0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s0_ready), .s_axis_tlast(s_last),
        .m_axis_tdata(m0_data), .m_axis_tvalid(m0_valid), .m_axis_tready(m_ready),
        .m_axis_tlast(m0_last), .m_axis_tuser(m0_user), .frame_count(fcnt0));

    always #5 aclk = ~aclk;

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Output collector plus stall-stability watch on every cycle.
    initial begin
        logic         held_v;
        logic [W+1:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge aclk);
            if (held_v) begin
                total++;
                if ({m_user, m_last, m_data} !== held || m_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h, want v=1 %h", m_valid, {m_user, m_last, m_data}, held);
                end
            end
            if (mon_en && m_valid === 1'b1 && m_ready)
                rx_q.push_back({m_user, m_last, m_data});
            held_v = aresetn && (m_valid === 1'b1) && !m_ready;
            held   = {m_user, m_last, m_data};
        end
    end

    // Must be entered just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic l, input int gap);
        int n;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            @(posedge aclk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        forever begin
            @(negedge aclk);
            if (s_ready) begin
                @(posedge aclk);
                #1;
                s_valid = 1'b0;
                s_data  = $urandom;
                break;
            end
            @(posedge aclk);
            #1;
            n++;
            if (n > 1000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got tready=0 for 1000 cycles, want 1");
                s_valid = 1'b0;
                break;
            end
        end
    endtask

    // Builds one frame: random payload (first word bits [6:0] zero) scrambled
    // with a keystream started from a random 7-bit history.
    function automatic void make_frame(input int nb,
                                       output logic [W-1:0] scr [0:19],
                                       output logic [W-1:0] orig[0:19]);
        bit         ks [0:20*W+6];
        logic [6:0] sd;
        sd = 7'($urandom);
        for (int i = 0; i < 7; i++) ks[i] = sd[i];
        for (int i = 7; i < 20*W+7; i++) ks[i] = ks[i-7] ^ ks[i-4];
        for (int b = 0; b < 20; b++) begin
            orig[b] = $urandom;
            if (b == 0) orig[b][6:0] = '0;
            for (int i = 0; i < W; i++) scr[b][i] = orig[b][i] ^ ks[7 + b*W + i];
        end
        for (int b = nb; b < 20; b++) begin
            orig[b] = '0;
            scr[b]  = '0;
        end
    endfunction

    task automatic test_reset;
        ready_mode = 2;
        s_valid = 1'b0; s_last = 1'b0; aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        total++; if (m_data !== '0)    begin bad++; $display("FAIL reset_data: got %h want 0", m_data); end
        total++; if ({m_last, m_user} !== 2'b00) begin bad++; $display("FAIL reset_last_user: got %b want 00", {m_last, m_user}); end
        total++; if (fcnt !== 16'h0)   begin bad++; $display("FAIL reset_fcnt: got %h want 0", fcnt); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", s_ready); end
        // garbage data with tvalid low must change nothing
        repeat (4) begin
            @(posedge aclk); #1;
            s_data = $urandom; s_last = 1'($urandom);
        end
        @(negedge aclk);
        total++; if (m_valid !== 1'b0 || fcnt !== 16'h0) begin
            bad++; $display("FAIL idle_no_change: got v=%b cnt=%h want v=0 cnt=0", m_valid, fcnt);
        end
        s_last = 1'b0;
        ready_mode = 0;
        @(posedge aclk); #1;
    endtask

    task automatic test_vectors;
        mon_en = 1'b0;
        send_beat(32'h40934F70, 1'b1, 0);
        total++; if (m_data !== 32'h0 || m_valid !== 1'b1) begin
            bad++; $display("FAIL vec_recover_data: got v=%b %h want v=1 00000000", m_valid, m_data);
        end
        total++; if ({m_user, m_last} !== 2'b11) begin bad++; $display("FAIL vec_recover_flags: got %b want 11", {m_user, m_last}); end
        total++; if (fcnt !== 16'd1) begin bad++; $display("FAIL vec_recover_fcnt: got %h want 0001", fcnt); end
        total++; if (m0_data !== 32'h0 || m0_valid !== 1'b1) begin
            bad++; $display("FAIL vec_seed_data: got v=%b %h want v=1 00000000", m0_valid, m0_data);
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic test_stream(input string name, input int rmode, input bit rgap, input int nfr);
        logic [W-1:0] scr [0:19];
        logic [W-1:0] orig[0:19];
        logic [W+1:0] got, want;
        int           nb, gap, idx;
        rx_q.delete(); exp_q.delete();
        mon_en = 1'b1;
        ready_mode = rmode;
        for (int f = 0; f < nfr; f++) begin
            nb = $urandom_range(1, 20);
            make_frame(nb, scr, orig);
            for (int b = 0; b < nb; b++) begin
                exp_q.push_back({(b == 0), (b == nb - 1), orig[b]});
                gap = (rgap && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                send_beat(scr[b], (b == nb - 1), gap);
            end
        end
        ready_mode = 0;
        for (int c = 0; c < 3000 && rx_q.size() < exp_q.size(); c++) @(posedge aclk);
        #1;
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s_count: got %0d beats want %0d", name, rx_q.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            got = rx_q.pop_front();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++; $display("FAIL %s beat %0d: got %h want %h", name, idx, got, want);
            end
            idx++;
        end
        mon_en = 1'b0;
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] scr [0:19];
        logic [W-1:0] orig[0:19];
        logic [W+1:0] got, want;
        int           nb;
        rx_q.delete();
        mon_en = 1'b1;
        make_frame(6, scr, orig);
        send_beat(scr[0], 1'b0, 0);
        send_beat(scr[1], 1'b0, 0);
        s_valid = 1'b1; s_data = scr[2]; s_last = 1'b0; aresetn = 1'b0;
        @(posedge aclk); #1;
        s_valid = 1'b0; aresetn = 1'b1;
        @(negedge aclk);
        total++; if (m_valid !== 1'b0 || m_data !== '0 || {m_last, m_user} !== 2'b00) begin
            bad++; $display("FAIL midreset_out: got v=%b %h l/u=%b want v=0 0 00", m_valid, m_data, {m_last, m_user});
        end
        total++; if (fcnt !== 16'h0) begin bad++; $display("FAIL midreset_fcnt: got %h want 0", fcnt); end
        for (int b = 0; b < 2; b++) begin
            want = {(b == 0), 1'b0, orig[b]};
            got  = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
            total++;
            if (got !== want) begin bad++; $display("FAIL midreset_pre beat %0d: got %h want %h", b, got, want); end
        end
        rx_q.delete();
        @(posedge aclk); #1;
        nb = $urandom_range(3, 8);
        make_frame(nb, scr, orig);
        for (int b = 0; b < nb; b++) send_beat(scr[b], (b == nb - 1), 0);
        for (int c = 0; c < 100 && rx_q.size() < nb; c++) @(posedge aclk);
        #1;
        total++; if (rx_q.size() != nb) begin bad++; $display("FAIL midreset_count: got %0d want %0d", rx_q.size(), nb); end
        for (int b = 0; b < nb && rx_q.size() > 0; b++) begin
            got = rx_q.pop_front();
            want = {(b == 0), (b == nb - 1), orig[b]};
            total++;
            if (got !== want) begin bad++; $display("FAIL midreset_post beat %0d: got %h want %h", b, got, want); end
        end
        total++; if (fcnt !== 16'd1) begin bad++; $display("FAIL midreset_fcnt_after: got %h want 0001", fcnt); end
        mon_en = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_wrap;
        logic [15:0] want;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        mon_en = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 16'hFFFE; i++) send_beat($urandom, 1'b1, 0);
        total++; if (fcnt !== 16'hFFFE) begin bad++; $display("FAIL wrap_preload: got %h want fffe", fcnt); end
        want = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            send_beat($urandom, 1'b0, $urandom_range(0, 2));
            send_beat($urandom, 1'b1, 0);
            want = want + 16'd1;
            total++; if (fcnt !== want) begin bad++; $display("FAIL wrap_step %0d: got %h want %h", i, fcnt, want); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stream("loopback", 0, 1'b0, 64);
        test_stream("backpressure", 1, 1'b1, 64);
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end
endmodule

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 Parameter WIDTH, default 32: tdata width in bits; SHALL be >= 8.
REQ-002 Parameter SEED, default 7'b1111111: LFSR load value at frame start when RECOVER=0.
REQ-003 Parameter RECOVER, default 1: 1 = recover LFSR state from the first 7 bits of each frame; 0 = load SEED.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 s_axis_tdata  in  WIDTH  scrambled data; bit 0 is first in time.
REQ-007 s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1 each  AXI-Stream slave handshake and end of frame.
REQ-008 m_axis_tdata  out  WIDTH  descrambled data, registered.
REQ-009 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  AXI-Stream master handshake and end of frame.
REQ-010 m_axis_tuser  out  1  high on the first beat of each output frame.
REQ-011 frame_count  out  16  count of completed input frames; wraps 0xFFFF -> 0x0000.

Function
REQ-012 Polynomial s^7+s^4+1: keystream x[i] = x[i-7] ^ x[i-4]; state S[0..6] holds x[-7..-1] relative to the current beat's bit 0.
REQ-013 Per beat: k[i] = x[i] for i = 0..WIDTH-1; next state = x[WIDTH-7..WIDTH-1].
REQ-014 FSM has two states, FIRST (next accepted beat starts a frame) and BODY; reset state is FIRST.
REQ-015 FIRST beat with RECOVER=1: x[0..6] = s_axis_tdata[6:0]; x[7..WIDTH-1] follow REQ-012; out[6:0] = 0; out[WIDTH-1:7] = in ^ k.
REQ-016 FIRST beat with RECOVER=0: S = SEED; out = in ^ k over all bits.
REQ-017 BODY beat: out = in ^ k using the stored S.
REQ-018 S updates only on an s-side handshake (s_axis_tvalid && s_axis_tready), to the next state of the accepted beat.
REQ-019 FIRST -> BODY on a handshake with tlast=0; any state -> FIRST on a handshake with tlast=1; single-beat frame stays in FIRST.
REQ-020 Output register: on an s-handshake, m_axis_tdata, m_axis_tlast = s_axis_tlast, m_axis_tuser = (state==FIRST), and m_axis_tvalid = 1 load; latency is 1 cycle.
REQ-021 s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational); full throughput when downstream is always ready.
REQ-022 m_axis_tvalid clears on an m-handshake without a simultaneous s-handshake; when both occur together, the new beat replaces the old and m_axis_tvalid stays 1.
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tuser SHALL hold stable.
REQ-024 frame_count increments by 1 on each s-handshake with s_axis_tlast=1.
REQ-025 s_axis_tdata is ignored when s_axis_tvalid=0; no state changes without a handshake.

Reset
REQ-026 On aresetn=0 at a clock edge: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, frame_count=0, S=SEED, FSM=FIRST.
REQ-027 Reset mid-frame discards the partial frame; the first beat after reset is treated as a frame start.
REQ-028 s_axis_tready SHALL be 1 in the first cycle after reset release.

Verification
REQ-029 RECOVER=1, WIDTH=32, single beat 0x40934F70 with tlast=1 -> output 0x00000000, tuser=1, tlast=1, frame_count=1.
REQ-030 RECOVER=0, SEED=7'h7F, single beat 0x40934F70 -> output 0x00000000.
REQ-031 Loopback: 64 random frames of 1-20 beats, first word bits [6:0]=0, scrambled with random seeds -> RECOVER=1 output matches the original bit-exactly, tuser only on each first beat.
REQ-032 Random m_axis_tready (about 50%) and random s_axis_tvalid gaps -> no lost, duplicated or changed beats; stall stability (REQ-023) checked every cycle.
REQ-033 aresetn pulsed mid-frame (beat 3 of 6) -> outputs reach REQ-026 values; the next frame descrambles correctly.
REQ-034 Preload frame_count near wrap (0xFFFE), then send 3 frames -> frame_count reads 0xFFFF, then 0x0000, then 0x0001.
